// File: rtl/nrn_seq_counter_if.sv
// -----------------------------------------------------------------------------
// nrn_seq_counter_if
// Control/index bundle between a neuron-layer sequencer and its consumer
// (weight memory, accumulator, bias adder).
//
// Parameters
//   NUM_IN   inputs (weights) per neuron
//   NUM_NRN  neurons per layer
//
// Signals
//   start    request one pass over all neurons
//   stall    freeze the sequencer while high
//   abort    synchronous return to idle
//   busy     sequencer is walking the weight array
//   in_idx   current input index within the neuron
//   nrn_idx  current neuron index
//   w_addr   flat weight address (nrn_idx*NUM_IN + in_idx)
//   acc_clr  accumulator clear (first input of a neuron)
//   en       bias-add enable (last input of a neuron, not stalled)
//   done     one-cycle pulse at the end of a pass
//
// Modports
//   master   drives start/stall/abort, observes the sequencer outputs
//   slave    the sequencer itself
// -----------------------------------------------------------------------------
interface nrn_seq_counter_if #(
    parameter int NUM_IN  = 32,
    parameter int NUM_NRN = 8
) ();
    localparam int IN_W   = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1;
    localparam int NRN_W  = ($clog2(NUM_NRN) > 1) ? $clog2(NUM_NRN) : 1;
    localparam int ADDR_W = ($clog2(NUM_IN * NUM_NRN) > 1) ? $clog2(NUM_IN * NUM_NRN) : 1;

    logic              start;
    logic              stall;
    logic              abort;
    logic              busy;
    logic [IN_W-1:0]   in_idx;
    logic [NRN_W-1:0]  nrn_idx;
    logic [ADDR_W-1:0] w_addr;
    logic              acc_clr;
    logic              en;
    logic              done;

    modport master (
        output start, stall, abort,
        input  busy, in_idx, nrn_idx, w_addr, acc_clr, en, done
    );

    modport slave (
        input  start, stall, abort,
        output busy, in_idx, nrn_idx, w_addr, acc_clr, en, done
    );
endinterface

// File: rtl/nrn_seq_counter.sv
// -----------------------------------------------------------------------------
// nrn_seq_counter
// Walks the weight array of one neural-network layer: for every neuron it
// steps through all inputs, producing the input/neuron indices, the flat
// weight address and the accumulator clear / bias-add strobes.
//
// Parameters
//   NUM_IN   inputs per neuron (2..1024, any value)
//   NUM_NRN  neurons per layer (1..256, any value)
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   bus      nrn_seq_counter_if.slave (start/stall/abort in; busy, in_idx,
//            nrn_idx, w_addr, acc_clr, en, done out)
//
// Build option
//   NRN_SEQ_AUTO_RESTART_EN  when defined, a start seen in DONE launches the
//                            next pass directly instead of returning to IDLE.
// -----------------------------------------------------------------------------
module nrn_seq_counter #(
    parameter int NUM_IN  = 32,
    parameter int NUM_NRN = 8
) (
    input  logic                clk,
    input  logic                rst,
    nrn_seq_counter_if.slave    bus
);
    localparam int IN_W   = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1;
    localparam int NRN_W  = ($clog2(NUM_NRN) > 1) ? $clog2(NUM_NRN) : 1;
    localparam int ADDR_W = ($clog2(NUM_IN * NUM_NRN) > 1) ? $clog2(NUM_IN * NUM_NRN) : 1;

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(NUM_IN - 1);
    localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(NUM_NRN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   in_q, in_d;
    logic [NRN_W-1:0]  nrn_q, nrn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_in;
    logic              last_nrn;

    assign last_in  = (in_q == IN_LAST);
    assign last_nrn = (nrn_q == NRN_LAST);

    // Next-state / index logic.
    // The flat address visits 0..N-1 in order, so it is kept as its own
    // incrementing register instead of being formed as nrn*NUM_IN+in.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        nrn_d   = nrn_q;
        addr_d  = addr_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            in_d    = '0;
            nrn_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                    in_d   = '0;
                    nrn_d  = '0;
                    addr_d = '0;
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        if (last_in) begin
                            in_d = '0;
                            if (last_nrn) begin
                                state_d = S_DONE;
                                nrn_d   = '0;
                                addr_d  = '0;
                            end else begin
                                nrn_d  = nrn_q + 1'b1;
                                addr_d = addr_q + 1'b1;
                            end
                        end else begin
                            in_d   = in_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
`ifdef NRN_SEQ_AUTO_RESTART_EN
                    state_d = bus.start ? S_RUN : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                    in_d   = '0;
                    nrn_d  = '0;
                    addr_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    in_d    = '0;
                    nrn_d   = '0;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            nrn_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            nrn_q   <= nrn_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them
    // without waiting for a clock edge.
    assign bus.busy    = (state_q == S_RUN);
    assign bus.in_idx  = in_q;
    assign bus.nrn_idx = nrn_q;
    assign bus.w_addr  = addr_q;
    assign bus.acc_clr = (state_q == S_RUN) && (in_q == '0);
    assign bus.en      = (state_q == S_RUN) && last_in && !bus.stall;
    assign bus.done    = (state_q == S_DONE);

endmodule

// File: doc/nrn_seq_counter.md
NRN_SEQ_COUNTER -- requirements
Module: nrn_seq_counter

Interface
REQ-001 Parameter NUM_IN, default 32: inputs (weights) per neuron; legal range 2..1024, not restricted to powers of two.
REQ-002 Parameter NUM_NRN, default 8: neurons per layer; legal range 1..256.
REQ-003 Derived widths: IN_W = max(1, clog2(NUM_IN)); NRN_W = max(1, clog2(NUM_NRN)); ADDR_W = max(1, clog2(NUM_IN*NUM_NRN)).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one pass over all neurons; sampled only in IDLE.
REQ-007 stall  input  1  freezes all counters and state while high in RUN.
REQ-008 abort  input  1  synchronous return to IDLE; highest priority after reset.
REQ-009 busy  output  1  high in RUN.
REQ-010 in_idx  output  IN_W  current input index; selects the weight.
REQ-011 nrn_idx  output  NRN_W  current neuron index.
REQ-012 w_addr  output  ADDR_W  flat weight address, equal to nrn_idx*NUM_IN + in_idx.
REQ-013 acc_clr  output  1  accumulator clear; high in RUN when in_idx==0.
REQ-014 en  output  1  bias-add enable; high in RUN when in_idx==NUM_IN-1 and stall==0.
REQ-015 done  output  1  single-cycle pulse when a pass completes.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE->RUN when start==1; in_idx and nrn_idx load 0 on the same edge.
REQ-018 RUN, stall==0: in_idx increments by 1 per cycle.
REQ-019 RUN, stall==0, in_idx==NUM_IN-1: in_idx wraps to 0 and nrn_idx increments by 1.
REQ-020 RUN, stall==0, in_idx==NUM_IN-1, nrn_idx==NUM_NRN-1: go to DONE; both indices clear to 0.
REQ-021 RUN, stall==1: state, indices and w_addr hold; acc_clr still reflects in_idx; en forced to 0.
REQ-022 DONE lasts exactly one cycle with done=1, then goes to IDLE unless REQ-033 applies.
REQ-023 start is ignored in RUN and in DONE, except as given in REQ-033.
REQ-024 abort==1 in any state: next state IDLE, indices 0; abort overrides start, stall and completion in the same cycle.
REQ-025 A pass of N=NUM_IN*NUM_NRN beats with no stalls takes N RUN cycles; done goes high N+1 cycles after the start edge.
REQ-026 w_addr is a registered output and advances in lockstep with the indices; no multiplier on the timing path.
REQ-027 Neither counter ever exceeds its terminal value (NUM_IN-1, NUM_NRN-1), including for non-power-of-two parameters.
REQ-028 Outputs in IDLE: busy=0, acc_clr=0, en=0, done=0, indices 0.

Reset
REQ-029 rst==0 forces IDLE immediately, asynchronously to clk.
REQ-030 Reset values: in_idx=0, nrn_idx=0, w_addr=0, busy=0, done=0, acc_clr=0, en=0.
REQ-031 Reset asserted mid-pass discards the pass; no done pulse is produced.
REQ-032 After rst deasserts, the first start is accepted on the first rising clk edge.

Configuration
REQ-033 With NRN_SEQ_AUTO_RESTART_EN defined, DONE with start==1 goes directly to RUN with indices 0; done still pulses for one cycle and back-to-back passes have a one-cycle gap.
REQ-034 Without NRN_SEQ_AUTO_RESTART_EN, DONE always goes to IDLE, and the earliest next pass starts two cycles after done.

Verification
REQ-035 NUM_IN=4, NUM_NRN=3, one start pulse, no stall -> w_addr 0..11 on consecutive cycles; en at w_addr 3, 7 and 11; done exactly 13 cycles after the start edge.
REQ-036 NUM_IN=5, NUM_NRN=2, stall high for 3 cycles at in_idx=2 -> in_idx/w_addr hold at 2, en stays 0, done is delayed by exactly 3 cycles.
REQ-037 abort asserted at nrn_idx=1, in_idx=3 -> next cycle IDLE, indices 0, no done pulse; a new start runs the full pass correctly.
REQ-038 rst pulled low mid-cycle during RUN -> outputs reach reset values before the next clk edge; no done pulse.
REQ-039 start held high continuously, NUM_IN=2, NUM_NRN=1 -> with the macro defined, done every 3 cycles; without it, done every 4 cycles.
REQ-040 NUM_IN=3, NUM_NRN=1 (non-power-of-two, single neuron) -> in_idx sequence 0,1,2, no index value 3 ever observed, nrn_idx constant 0.
